memory_io_bridge: RTL
=====================

// Module: memory_io_bridge
// PURPOSE
//  Memory/IO stage directly downstream of the multicycle processor. Consumes
//  the processor's AddressOut, DOUT and Write outputs, and drives an external
//  synchronous single-port RAM, a LED register and a synchronised switch input.
//  Returns read data on DIN with a fixed latency of 2 clock edges, which matches
//  the processor's fetch wait in T1..T2 and its capture in T3.
// PARAMETERS
//  DATA_W  16  width of the data bus, AddressOut and DIN
//  RAM_AW  7   RAM word-address width (128 words)
//  LED_W   10  LED register width
//  SW_W    10  switch input width
// PORTS
//  Clock       in   1        single system clock; all state updates on its rising edge
//  Resetn      in   1        reset, asynchronous, active-high (name kept from codebase)
//  AddressOut  in   DATA_W   address from processor (registered in processor)
//  DOUT        in   DATA_W   write data from processor
//  Write       in   1        write strobe from processor, one cycle wide
//  DIN         out  DATA_W   registered read data to processor
//  RamAddr     out  RAM_AW   RAM address (registered)
//  RamWrData   out  DATA_W   RAM write data (registered)
//  RamWe       out  1        RAM write enable (registered)
//  RamRdData   in   DATA_W   RAM read data, valid 1 edge after RamAddr
//  SW          in   SW_W     raw switches (asynchronous)
//  LEDR        out  LED_W    LED register
//  BusError    out  1        sticky bad-access flag
// BEHAVIOUR
//  Address map, decoded from AddressOut[15:12]:
//   0x0 = RAM (word AddressOut[RAM_AW-1:0]; bits [11:RAM_AW] ignored, aliased)
//   0x1 = LED  (R/W; read returns {0, LEDR})
//   0x3 = SW   (read-only; read returns {0, sw_sync})
//   any other value = unmapped
//  Reset (async, Resetn=1): DIN=0, RamAddr=0, RamWrData=0, RamWe=0, LEDR=0,
//   BusError=0, both switch sync flops=0, stage-1 region=unmapped, fwd_valid=0.
//  Stage 1 (every edge): register RamAddr<=AddressOut[RAM_AW-1:0], region<=decode,
//   RamWrData<=DOUT, RamWe<=Write & (region==RAM). LEDR<=DOUT[LED_W-1:0] on the
//   edge where Write & region==LED.
//  Stage 2 (next edge): DIN <= RAM? (fwd_valid ? fwd_data : RamRdData)
//   : LED? LEDR : SW? sw_sync : 0.
//  Read latency: AddressOut stable at edge N -> DIN valid after edge N+2 and
//   held while the address is stable. No handshake; the processor waits fixed cycles.
//  Write-then-read forwarding: if RamWe is high at edge N and the stage-1 address
//   equals the stage-1 address of the following read, stage 2 returns the written
//   RamWrData (fwd_valid, fwd_data) instead of the stale RamRdData.
//  Write and read same cycle: the write is performed. DIN reflects the new value
//   2 edges later (LED) or via forwarding (RAM).
//  Switches: 2-flop synchroniser, so a new SW value is visible in DIN at the latest
//   4 edges after it changes.
//  BusError: set on the edge after any Write to SW or to an unmapped region, or
//   after any read whose region is unmapped (region is unmapped at stage 2 and
//   the address changed). Cleared only by reset. A read of unmapped space returns 0.
//  Reset mid-access: pending RamWe is dropped; the RAM contents are not affected by
//   the bridge.
//  Arithmetic: none; all widths are zero-extended to DATA_W on read.
// TESTING
//  1. Reset then AddressOut=0x0005, RamRdData=0xBEEF one edge later -> RamAddr=5
//     after edge 1, DIN=0xBEEF after edge 2; DIN=0 before that.
//  2. Write=1, AddressOut=0x0010, DOUT=0x1234, then a read of 0x0010 -> RamWe=1
//     for one cycle with RamWrData=0x1234; DIN=0x1234 via forwarding.
//  3. Write 0x03FF to 0x1000 -> LEDR=0x3FF the edge after; read 0x1000 -> DIN=0x03FF.
//  4. SW=0x2A5, read 0x3000 -> DIN=0x02A5 within 4 edges; write 0x3000 -> BusError=1,
//     LEDR unchanged.
//  5. Read 0x7000 -> DIN=0, BusError=1 and stays 1 until reset.
//  6. Assert Resetn mid-write (Write=1, RAM region) -> RamWe=0, LEDR=0, DIN=0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/memory_io_bridge.sv
// Memory/IO stage behind the multicycle processor: RAM, LED register and synchronised switches.
// Read data appears on DIN two edges after the address; there is no handshake and the bridge never stalls.
module memory_io_bridge #(
  parameter int DATA_W = 16,
  parameter int RAM_AW = 7,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] AddressOut,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              Write,
  output logic [DATA_W-1:0] DIN,
  output logic [RAM_AW-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWrData,
  output logic              RamWe,
  input  logic [DATA_W-1:0] RamRdData,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LEDR,
  output logic              BusError
);

  typedef enum logic [1:0] {
    RGN_UNMAP = 2'd0,
    RGN_RAM   = 2'd1,
    RGN_LED   = 2'd2,
    RGN_SW    = 2'd3
  } region_t;

  region_t             region_in;
  region_t             region_d, region_q;
  logic [RAM_AW-1:0]   ram_addr_d, ram_addr_q;
  logic [DATA_W-1:0]   ram_wr_data_d, ram_wr_data_q;
  logic                ram_we_d, ram_we_q;
  logic [LED_W-1:0]    led_d, led_q;
  logic [DATA_W-1:0]   addr_d, addr_q;
  logic                addr_chg_d, addr_chg_q;
  logic                fwd_valid_d, fwd_valid_q;
  logic [DATA_W-1:0]   fwd_data_d, fwd_data_q;
  logic [SW_W-1:0]     sw_meta_d, sw_meta_q;
  logic [SW_W-1:0]     sw_sync_d, sw_sync_q;
  logic [DATA_W-1:0]   din_d, din_q;
  logic                bus_err_d, bus_err_q;

  always_comb begin
    region_in = RGN_UNMAP;
    case (AddressOut[DATA_W-1 -: 4])
      4'h0:    region_in = RGN_RAM;
      4'h1:    region_in = RGN_LED;
      4'h3:    region_in = RGN_SW;
      default: region_in = RGN_UNMAP;
    endcase
  end

  always_comb begin
    region_d      = region_in;
    ram_addr_d    = AddressOut[RAM_AW-1:0];
    ram_wr_data_d = DOUT;
    ram_we_d      = Write && (region_in == RGN_RAM);
    addr_d        = AddressOut;
    addr_chg_d    = (AddressOut != addr_q);
    sw_meta_d     = SW;
    sw_sync_d     = sw_meta_q;

    led_d = led_q;
    if (Write && (region_in == RGN_LED)) begin
      led_d = DOUT[LED_W-1:0];
    end

    // The RAM word being written this cycle may be read back before it lands in the array.
    fwd_valid_d = ram_we_q && (region_in == RGN_RAM) && (AddressOut[RAM_AW-1:0] == ram_addr_q);
    fwd_data_d  = ram_wr_data_q;

    din_d = '0;
    case (region_q)
      RGN_RAM: din_d = fwd_valid_q ? fwd_data_q : RamRdData;
      RGN_LED: din_d = {{(DATA_W-LED_W){1'b0}}, led_q};
      RGN_SW:  din_d = {{(DATA_W-SW_W){1'b0}}, sw_sync_q};
      default: din_d = '0;
    endcase

    // addr_chg_q keeps the post-reset unmapped region from raising a false error.
    bus_err_d = bus_err_q;
    if (Write && ((region_in == RGN_SW) || (region_in == RGN_UNMAP))) begin
      bus_err_d = 1'b1;
    end
    if ((region_q == RGN_UNMAP) && addr_chg_q) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      region_q      <= RGN_UNMAP;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_we_q      <= 1'b0;
      led_q         <= '0;
      addr_q        <= '0;
      addr_chg_q    <= 1'b0;
      fwd_valid_q   <= 1'b0;
      fwd_data_q    <= '0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      din_q         <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      region_q      <= region_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_we_q      <= ram_we_d;
      led_q         <= led_d;
      addr_q        <= addr_d;
      addr_chg_q    <= addr_chg_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_data_q    <= fwd_data_d;
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      din_q         <= din_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign DIN       = din_q;
  assign RamAddr   = ram_addr_q;
  assign RamWrData = ram_wr_data_q;
  assign RamWe     = ram_we_q;
  assign LEDR      = led_q;
  assign BusError  = bus_err_q;

endmodule
